// File: rtl/mips_multicycle_ctrl_if.sv
// Control/datapath bundle for the multicycle MIPS sequencer: run enable, fetch
// handshake and decoded instruction fields in; write strobes and status out.
interface mips_multicycle_ctrl_if;
    logic       EN;
    logic       MemReady;
    logic [5:0] Opcode;
    logic [5:0] FuncCode;
    logic       PCWrite;
    logic       IRWrite;
    logic       ABWrite;
    logic [1:0] ALUOp;
    logic       ALUOutWrite;
    logic       RegWrite;
    logic       Busy;
    logic       Illegal;
    logic [2:0] State;

    // master: the control sequencer, which owns every datapath write enable
    modport master (
        input  EN, MemReady, Opcode, FuncCode,
        output PCWrite, IRWrite, ABWrite, ALUOp, ALUOutWrite, RegWrite,
               Busy, Illegal, State
    );

    modport slave (
        output EN, MemReady, Opcode, FuncCode,
        input  PCWrite, IRWrite, ABWrite, ALUOp, ALUOutWrite, RegWrite,
               Busy, Illegal, State
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle R-type MIPS control sequencer (fetch, decode, exec, write-back).
// Optional retire counter enabled by defining MIPS_CTRL_PERF_CNT_EN.
//
// state  | meaning
// IDLE   | stopped, waiting for EN
// FETCH  | waiting on MemReady; IR/PC load on the ready cycle
// DECODE | latch A/B, classify the instruction
// EXEC   | R-type ALU op, latch ALU result
// WB     | register-file write, retire
// TRAP   | illegal instruction seen; parked until reset
module mips_multicycle_ctrl #(
    parameter bit RESET_PC_HOLD = 1'b0
) (
    input  logic                  CLK,
    input  logic                  RESET,
    mips_multicycle_ctrl_if.master bus
`ifdef MIPS_CTRL_PERF_CNT_EN
    ,
    output logic [31:0]           RetireCount
`endif
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_e;

    state_e     state_q, state_d;
    logic       first_fetch_q, first_fetch_d;
    logic       legal;
    logic       ir_write, pc_write, ab_write;
    logic [1:0] alu_op;
    logic       alu_out_write, reg_write, busy, illegal;

    always_comb begin
        legal = 1'b0;
        if (bus.Opcode == 6'h00) begin
            case (bus.FuncCode)
                6'd32, 6'd34, 6'd36, 6'd37, 6'd39, 6'd42: legal = 1'b1;
                default:                                   legal = 1'b0;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q       <= S_IDLE;
            first_fetch_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            first_fetch_q <= first_fetch_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        first_fetch_d = first_fetch_q;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        ab_write      = 1'b0;
        alu_op        = 2'b00;
        alu_out_write = 1'b0;
        reg_write     = 1'b0;
        busy          = 1'b0;
        illegal       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.EN) state_d = S_FETCH;
            end
            S_FETCH: begin
                busy = 1'b1;
                if (bus.MemReady) begin
                    ir_write      = 1'b1;
                    // optional hold makes the very first fetch re-read address 0
                    pc_write      = ~(RESET_PC_HOLD && first_fetch_q);
                    first_fetch_d = 1'b0;
                    state_d       = S_DECODE;
                end
            end
            S_DECODE: begin
                busy     = 1'b1;
                ab_write = 1'b1;
                state_d  = legal ? S_EXEC : S_TRAP;
            end
            S_EXEC: begin
                busy          = 1'b1;
                alu_op        = 2'b10;
                alu_out_write = 1'b1;
                state_d       = S_WB;
            end
            S_WB: begin
                busy      = 1'b1;
                reg_write = 1'b1;
                state_d   = bus.EN ? S_FETCH : S_IDLE;
            end
            S_TRAP: begin
                illegal = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.IRWrite     = ir_write;
    assign bus.PCWrite     = pc_write;
    assign bus.ABWrite     = ab_write;
    assign bus.ALUOp       = alu_op;
    assign bus.ALUOutWrite = alu_out_write;
    assign bus.RegWrite    = reg_write;
    assign bus.Busy        = busy;
    assign bus.Illegal     = illegal;
    assign bus.State       = state_q;

`ifdef MIPS_CTRL_PERF_CNT_EN
    logic [31:0] retire_q;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            retire_q <= 32'd0;
        end else if (state_q == S_WB) begin
            retire_q <= retire_q + 32'd1;
        end
    end

    assign RetireCount = retire_q;
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: instruction table plus
// hand-written sequences for EN drop, mid-instruction reset and traps.
module tb_mips_multicycle_ctrl;

    logic CLK   = 1'b0;
    logic RESET = 1'b0;

    mips_multicycle_ctrl_if bus ();

`ifdef MIPS_CTRL_PERF_CNT_EN
    logic [31:0] ret_count;
`endif

    mips_multicycle_ctrl #(.RESET_PC_HOLD(1'b0)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .bus         (bus)
`ifdef MIPS_CTRL_PERF_CNT_EN
        ,
        .RetireCount (ret_count)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        int         waits;
        bit         legal;
        string      name;
    } vec_t;

    vec_t        vecs[10];
    logic [11:0] sb[$];
    string       sb_name[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    int          exp_ret = 0;

    // packed {State, IRWrite, PCWrite, ABWrite, ALUOp, ALUOutWrite, RegWrite, Busy, Illegal}
    function automatic logic [11:0] model(input int st, input logic mr);
        case (st)
            0:       return {3'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
            1:       return {3'd1, mr,   mr,   1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0};
            2:       return {3'd2, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0};
            3:       return {3'd3, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0};
            4:       return {3'd4, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0};
            default: return {3'd5, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1};
        endcase
    endfunction

    task automatic check_out();
        logic [11:0] got, exp;
        string       nm;
        got = {bus.State, bus.IRWrite, bus.PCWrite, bus.ABWrite, bus.ALUOp,
               bus.ALUOutWrite, bus.RegWrite, bus.Busy, bus.Illegal};
        exp = sb.pop_front();
        nm  = sb_name.pop_front();
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got st/strobes %b required %b (t=%0t)", nm, got, exp, $time);
        end
`ifdef MIPS_CTRL_PERF_CNT_EN
        n_chk++;
        if (ret_count !== 32'(exp_ret)) begin
            n_fail++;
            $display("FAIL %s_retire: got %0d required %0d", nm, ret_count, exp_ret);
        end
`endif
    endtask

    task automatic expect_now(input int st, input logic mr, input string nm);
        sb.push_back(model(st, mr));
        sb_name.push_back(nm);
        check_out();
    endtask

    task automatic cyc(input logic en, input logic mr, input logic [5:0] op,
                       input logic [5:0] fn, input int st, input string nm);
        @(negedge CLK);
        bus.EN       = en;
        bus.MemReady = mr;
        bus.Opcode   = op;
        bus.FuncCode = fn;
        #1;
        expect_now(st, mr, nm);
    endtask

    task automatic reset_pulse(input string nm);
        @(negedge CLK);
        RESET        = 1'b0;
        bus.EN       = 1'b1;
        bus.MemReady = 1'b1;
        #1;
        exp_ret = 0;
        expect_now(0, 1'b1, nm);
        @(negedge CLK);
        RESET  = 1'b1;
        bus.EN = 1'b0;
    endtask

    task automatic run_instr(input vec_t v);
        for (int w = 0; w < v.waits; w++) cyc(1'b1, 1'b0, 6'h00, 6'h00, 1, {v.name, "_fetch_wait"});
        cyc(1'b1, 1'b1, 6'h00, 6'h00, 1, {v.name, "_fetch"});
        cyc(1'b1, 1'b1, v.op, v.fn, 2, {v.name, "_decode"});
        if (v.legal) begin
            cyc(1'b1, 1'b1, v.op, v.fn, 3, {v.name, "_exec"});
            cyc(1'b1, 1'b1, v.op, v.fn, 4, {v.name, "_wb"});
            exp_ret++;
        end else begin
            cyc(1'b1, 1'b1, v.op, v.fn, 5, {v.name, "_trap"});
            cyc(1'b0, 1'b0, v.op, v.fn, 5, {v.name, "_trap_en0"});
            cyc(1'b1, 1'b1, v.op, v.fn, 5, {v.name, "_trap_en1"});
            cyc(1'b0, 1'b1, v.op, v.fn, 5, {v.name, "_trap_hold"});
            reset_pulse({v.name, "_trap_reset"});
            cyc(1'b1, 1'b1, 6'h00, 6'h00, 0, {v.name, "_restart_idle"});
        end
    endtask

    initial begin
        vecs[0] = '{6'h00, 6'd36, 0, 1'b1, "and"};
        vecs[1] = '{6'h00, 6'd37, 0, 1'b1, "or"};
        vecs[2] = '{6'h00, 6'd34, 0, 1'b1, "sub"};
        vecs[3] = '{6'h00, 6'd32, 3, 1'b1, "add_wait3"};
        vecs[4] = '{6'h00, 6'd39, 1, 1'b1, "nor_wait1"};
        vecs[5] = '{6'h00, 6'd42, 0, 1'b1, "slt"};
        vecs[6] = '{6'h00, 6'd38, 0, 1'b0, "xor_illegal"};
        vecs[7] = '{6'h00, 6'h3F, 2, 1'b0, "fn3f_illegal"};
        vecs[8] = '{6'h02, 6'd32, 0, 1'b0, "op2_illegal"};
        vecs[9] = '{6'h00, 6'd32, 0, 1'b1, "add"};

        RESET        = 1'b0;
        bus.EN       = 1'b1;
        bus.MemReady = 1'b1;
        bus.Opcode   = 6'h00;
        bus.FuncCode = 6'd32;

        cyc(1'b1, 1'b1, 6'h00, 6'd32, 0, "reset_a");
        cyc(1'b1, 1'b1, 6'h00, 6'd32, 0, "reset_b");
        @(negedge CLK);
        RESET  = 1'b1;
        bus.EN = 1'b0;
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 6'h00, 6'd32, 0, "idle_hold");

        cyc(1'b1, 1'b1, 6'h00, 6'h00, 0, "idle_en");
        for (int i = 0; i < 10; i++) run_instr(vecs[i]);

        // EN dropped in EXEC: instruction still retires, then IDLE
        cyc(1'b1, 1'b1, 6'h00, 6'h00, 1, "drop_fetch");
        cyc(1'b1, 1'b1, 6'h00, 6'd32, 2, "drop_decode");
        cyc(1'b0, 1'b1, 6'h00, 6'd32, 3, "drop_exec");
        cyc(1'b0, 1'b1, 6'h00, 6'd32, 4, "drop_wb");
        exp_ret++;
        cyc(1'b0, 1'b1, 6'h00, 6'd32, 0, "drop_idle");
        cyc(1'b0, 1'b1, 6'h00, 6'd32, 0, "drop_idle2");

        // EN dropped in FETCH while memory is stalled
        cyc(1'b1, 1'b0, 6'h00, 6'h00, 0, "fdrop_idle_en");
        cyc(1'b0, 1'b0, 6'h00, 6'h00, 1, "fdrop_wait");
        cyc(1'b0, 1'b1, 6'h00, 6'h00, 1, "fdrop_fetch");
        cyc(1'b0, 1'b1, 6'h00, 6'd42, 2, "fdrop_decode");
        cyc(1'b0, 1'b1, 6'h00, 6'd42, 3, "fdrop_exec");
        cyc(1'b0, 1'b1, 6'h00, 6'd42, 4, "fdrop_wb");
        exp_ret++;
        cyc(1'b0, 1'b1, 6'h00, 6'd42, 0, "fdrop_idle");

        // asynchronous reset in the middle of EXEC: no write-back
        cyc(1'b1, 1'b1, 6'h00, 6'h00, 0, "rst_idle_en");
        cyc(1'b1, 1'b1, 6'h00, 6'h00, 1, "rst_fetch");
        cyc(1'b1, 1'b1, 6'h00, 6'd32, 2, "rst_decode");
        cyc(1'b1, 1'b1, 6'h00, 6'd32, 3, "rst_exec");
        #2;
        RESET = 1'b0;
        #1;
        exp_ret = 0;
        expect_now(0, 1'b1, "rst_mid_exec");
        @(negedge CLK);
        RESET  = 1'b1;
        bus.EN = 1'b0;
        cyc(1'b0, 1'b1, 6'h00, 6'd32, 0, "rst_no_wb");
        cyc(1'b0, 1'b1, 6'h00, 6'd32, 0, "rst_idle_hold");

        if (sb.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left required 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multicycle control sequencer for the R-type MIPS datapath (PC, instruction memory, instruction register, register file, ALU control, ALU). Replaces free-running per-clock updates with a state machine. Each instruction is stepped through fetch, decode/operand read, execute and write-back, with strobes to the PC, IR, A/B latches, ALU output latch and register file. Sits beside the datapath in the top level and is the only source of its write enables.

## Interface
Parameters:
- RESET_PC_HOLD, 0, when 1 PCWrite is suppressed in the first FETCH after reset (PC re-fetches address 0 twice); 0 = normal

Ports:
- CLK  in  1  system clock, rising-edge
- RESET  in  1  asynchronous, active-low reset
- EN  in  1  run enable; sampled in IDLE and WB
- MemReady  in  1  instruction memory data valid (fetch handshake)
- Opcode  in  6  INSTRUCTION[31:26], valid from the cycle after IRWrite
- FuncCode  in  6  INSTRUCTION[5:0], valid from the cycle after IRWrite
- PCWrite  out  1  PC load strobe (PC <= PC+4)
- IRWrite  out  1  instruction register load strobe
- ABWrite  out  1  register-file read latch strobe (A, B)
- ALUOp  out  2  00 = add (default), 10 = R-type, decode by FuncCode
- ALUOutWrite  out  1  ALU result latch strobe
- RegWrite  out  1  register-file write strobe
- Busy  out  1  high in FETCH, DECODE, EXEC, WB
- Illegal  out  1  sticky illegal-instruction flag
- State  out  3  current state encoding (debug)

## Operation
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4, TRAP=5. Codes 6 and 7 go to IDLE on the next edge.
- IDLE: if EN=1 then FETCH, else hold.
- FETCH: IRWrite = PCWrite = MemReady (Mealy). If MemReady=1 then DECODE, else hold with no strobes.
- DECODE: ABWrite=1. The instruction is legal when Opcode=6'h00 and FuncCode is one of {32,34,36,37,39,42}. Legal goes to EXEC. Illegal goes to TRAP and sets Illegal on the same edge.
- EXEC: ALUOp=10 and ALUOutWrite=1, then WB.
- WB: RegWrite=1. If EN=1 then FETCH, else IDLE.
- TRAP: all strobes 0, Busy=0, Illegal=1. Held until reset; EN and MemReady are ignored.
- All outputs other than IRWrite and PCWrite are Moore-decoded from the state register. ALUOp=00 in every state except EXEC.
- Exactly one RegWrite pulse per retired instruction. An illegal instruction never asserts ALUOutWrite or RegWrite.

## Timing
- Reset values: State=0 (IDLE), all strobes 0, ALUOp=00, Busy=0, Illegal=0.
- Reset asserted mid-instruction: return to IDLE immediately (asynchronous). No further strobe is issued for that instruction. The partial instruction is discarded, not retired.
- Latency with MemReady=1: 4 cycles per instruction, giving CPI 4 with EN held high. Each cycle of MemReady=0 in FETCH adds 1 cycle.
- EN deasserted in FETCH, DECODE or EXEC: the current instruction completes through WB, then the FSM goes to IDLE.
- EN=1 in IDLE: FETCH on the next edge, first IRWrite no earlier than cycle 2 after EN rises.
- When MemReady rises and falls in the same FETCH cycle, only the value sampled at the rising CLK edge counts.

## Configuration
- MIPS_CTRL_PERF_CNT_EN defined: adds output port RetireCount [31:0].
  - Reset value 0.
  - Increments by 1 on every edge leaving WB; wraps 32'hFFFFFFFF to 0.
  - Unaffected by TRAP.
- MIPS_CTRL_PERF_CNT_EN undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Reset: RESET=0 with EN=1 and MemReady=1 → State=0, all strobes 0, Illegal=0. Release, EN=0 → stays IDLE indefinitely.
- ADD, Opcode=0, FuncCode=32, EN=1, MemReady=1 → State sequence 0,1,2,3,4,1. IRWrite/PCWrite in state 1, ABWrite in state 2, ALUOp=10 and ALUOutWrite in state 3, RegWrite in state 4, each exactly one cycle.
- MemReady=0 for 3 cycles in FETCH → State=1 for 4 cycles. IRWrite/PCWrite only in the 4th. Total instruction time 7 cycles.
- FuncCode=0x3F (or Opcode=0x02 with FuncCode=32) → DECODE then TRAP (5). Illegal=1, no ALUOutWrite/RegWrite. Toggling EN has no effect; RESET=0 clears to IDLE with Illegal=0.
- EN dropped during EXEC → WB completes with RegWrite=1, then IDLE. Reset pulsed during EXEC → IDLE at once, no RegWrite.
- With MIPS_CTRL_PERF_CNT_EN, run AND, OR, SUB (FuncCode 36, 37, 34) back-to-back → RetireCount=3 after the third WB. Reset → 0.
